mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 11, memory word-address width.
REQ-002 Parameter DATA_W, default 32, memory data width.
REQ-003 Parameter RD_LAT, default 2, legal 1..4: clock edges from address presentation to valid mem_dout.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 inst_req  input  1  instruction-fetch read request, held until inst_gnt.
REQ-007 inst_addr  input  ADDR_W  fetch address, stable while inst_req high.
REQ-008 inst_gnt  output  1  one-cycle pulse: fetch request accepted.
REQ-009 inst_rvalid  output  1  one-cycle pulse: inst_rdata valid.
REQ-010 inst_rdata  output  DATA_W  fetched word.
REQ-011 data_req  input  1  data-port request, held until data_gnt.
REQ-012 data_we  input  1  1 = write, 0 = read.
REQ-013 data_addr  input  ADDR_W  data address, stable while data_req high.
REQ-014 data_wdata  input  DATA_W  write data, stable while data_req high.
REQ-015 data_gnt  output  1  one-cycle pulse: data request accepted.
REQ-016 data_rvalid  output  1  one-cycle pulse: data_rdata valid (reads only).
REQ-017 data_rdata  output  DATA_W  read word.
REQ-018 mem_wea  output  1  BRAM write enable.
REQ-019 mem_addr  output  ADDR_W  BRAM address.
REQ-020 mem_din  output  DATA_W  BRAM write data.
REQ-021 mem_dout  input  DATA_W  BRAM read data.
REQ-022 busy  output  1  high whenever state is not IDLE.

Function
REQ-023 FSM states: IDLE, WR, RD; one transaction outstanding at a time; all outputs registered.
REQ-024 IDLE, no request: remain IDLE, mem_wea=0, mem_addr/mem_din hold.
REQ-025 IDLE, request present at edge E0: select owner, mem_addr<=owner addr, mem_din<=data_wdata (data owner), owner gnt<=1 for exactly one cycle (E0 to E1).
REQ-026 Arbitration: single requester wins; both requesting -> requester not served last wins (round-robin); last_owner updates at each accept.
REQ-027 Data write accept: mem_wea<=1 at E0, state WR; at E1 mem_wea<=0, state IDLE; next accept earliest E2; no rvalid for writes.
REQ-028 Read accept: mem_wea<=0, cnt<=1, state RD.
REQ-029 RD, cnt != RD_LAT: cnt<=cnt+1.
REQ-030 RD, cnt == RD_LAT (edge E0+RD_LAT): owner rdata<=mem_dout, owner rvalid<=1 for one cycle, state IDLE; next accept earliest E0+RD_LAT+1.
REQ-031 Requests are not sampled outside IDLE; a request arriving mid-transaction waits, not dropped.
REQ-032 rdata registers hold their value until the next read completion for that port.
REQ-033 Address is passed unmodified; addresses 0 and 2^ADDR_W-1 need no special handling.

Reset
REQ-034 rst high at an edge: state IDLE, cnt 0, last_owner = data (fetch wins first tie), all gnt/rvalid/mem_wea 0, mem_addr/mem_din/inst_rdata/data_rdata 0, busy 0.
REQ-035 rst during WR or RD aborts the transaction: no rvalid issued, mem_wea 0 from that edge.

Verification (RD_LAT=2 unless noted)
REQ-036 BRAM[5]=0xDEADBEEF, inst_req addr 5 accepted at E0 -> inst_gnt high E0-E1, inst_rvalid high E2-E3 with inst_rdata=0xDEADBEEF, busy high E0-E2.
REQ-037 data write addr 0x7FF wdata 0x12345678, then data read 0x7FF -> mem_wea high exactly one cycle; data_rdata=0x12345678, data_rvalid one pulse.
REQ-038 inst_req and data_req both rise after reset -> inst served first, data next; next simultaneous pair -> data first.
REQ-039 inst_req held continuously, data_req raised once -> data_gnt within the second accept after data_req rises; no fetch starvation.
REQ-040 rst asserted in RD with cnt=1 -> no rvalid on either port, all outputs 0 next cycle, new request accepted normally afterwards.
REQ-041 RD_LAT=4, data read addr 3 -> data_rvalid exactly 4 edges after accept edge with BRAM[3] contents.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported BRAM between an instruction-fetch port (read only)
// and a data port (read/write). One transaction is outstanding at a time.
// When both ports request in the same idle cycle, the port not served last
// wins. Every output is a flop.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   inst_req/inst_addr        fetch request, held until inst_gnt
//   inst_gnt                  one-cycle accept pulse for the fetch port
//   inst_rvalid/inst_rdata    one-cycle read-return pulse plus held fetch word
//   data_req/data_we/
//   data_addr/data_wdata      data request (write when data_we=1), held until data_gnt
//   data_gnt                  one-cycle accept pulse for the data port
//   data_rvalid/data_rdata    one-cycle read-return pulse plus held read word
//   mem_wea/mem_addr/mem_din  BRAM write enable, address, write data
//   mem_dout                  BRAM read data, valid RD_LAT edges after the address
//   busy                      high while a transaction is in flight
module mem_port_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_gnt,
    output logic              inst_rvalid,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_gnt,
    output logic              data_rvalid,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_wea,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, WR, RD} state_t;

    localparam logic [2:0] LAT = 3'(RD_LAT);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              last_data_q, last_data_d;  // 1: data port was served last
    logic              own_data_q, own_data_d;    // 1: current read belongs to data port
    logic              pick_data;
    logic              inst_gnt_d, data_gnt_d;
    logic              inst_rvalid_d, data_rvalid_d;
    logic [DATA_W-1:0] inst_rdata_d, data_rdata_d;
    logic              mem_wea_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_din_d;
    logic              busy_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_data_d   = last_data_q;
        own_data_d    = own_data_q;
        pick_data     = 1'b0;
        inst_gnt_d    = 1'b0;
        data_gnt_d    = 1'b0;
        inst_rvalid_d = 1'b0;
        data_rvalid_d = 1'b0;
        inst_rdata_d  = inst_rdata;
        data_rdata_d  = data_rdata;
        mem_wea_d     = 1'b0;
        mem_addr_d    = mem_addr;
        mem_din_d     = mem_din;

        case (state_q)
            IDLE: begin
                if (inst_req || data_req) begin
                    // On a tie the port that was not served last goes first.
                    pick_data   = data_req && (!inst_req || !last_data_q);
                    last_data_d = pick_data;
                    own_data_d  = pick_data;
                    if (pick_data) begin
                        data_gnt_d = 1'b1;
                        mem_addr_d = data_addr;
                        mem_din_d  = data_wdata;
                        if (data_we) begin
                            mem_wea_d = 1'b1;
                            state_d   = WR;
                        end else begin
                            cnt_d   = 3'd1;
                            state_d = RD;
                        end
                    end else begin
                        inst_gnt_d = 1'b1;
                        mem_addr_d = inst_addr;
                        cnt_d      = 3'd1;
                        state_d    = RD;
                    end
                end
            end
            WR: begin
                // Write strobe lasts exactly the one cycle after accept.
                state_d = IDLE;
            end
            RD: begin
                if (cnt_q == LAT) begin
                    cnt_d   = 3'd0;
                    state_d = IDLE;
                    if (own_data_q) begin
                        data_rdata_d  = mem_dout;
                        data_rvalid_d = 1'b1;
                    end else begin
                        inst_rdata_d  = mem_dout;
                        inst_rvalid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            last_data_q <= 1'b1;
            own_data_q  <= 1'b0;
            inst_gnt    <= 1'b0;
            data_gnt    <= 1'b0;
            inst_rvalid <= 1'b0;
            data_rvalid <= 1'b0;
            inst_rdata  <= '0;
            data_rdata  <= '0;
            mem_wea     <= 1'b0;
            mem_addr    <= '0;
            mem_din     <= '0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_data_q <= last_data_d;
            own_data_q  <= own_data_d;
            inst_gnt    <= inst_gnt_d;
            data_gnt    <= data_gnt_d;
            inst_rvalid <= inst_rvalid_d;
            data_rvalid <= data_rvalid_d;
            inst_rdata  <= inst_rdata_d;
            data_rdata  <= data_rdata_d;
            mem_wea     <= mem_wea_d;
            mem_addr    <= mem_addr_d;
            mem_din     <= mem_din_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model (accept edge, owner, expected
// return edge and word computed from the arbitration and latency rules).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    // RD_LAT = 2 instance
    logic        ireq, dreq, dwe;
    logic [10:0] iaddr, daddr, maddr;
    logic [31:0] dwdata, irdata, drdata, mdin, mdout;
    logic        igt, irv, dgt, drv, wea, busy;
    // RD_LAT = 4 instance
    logic        ireq4, dreq4, dwe4;
    logic [10:0] iaddr4, daddr4, maddr4;
    logic [31:0] dwdata4, irdata4, drdata4, mdin4, mdout4;
    logic        igt4, irv4, dgt4, drv4, wea4, busy4;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(11), .DATA_W(32), .RD_LAT(2)) dut (
        .clk(clk), .rst(rst),
        .inst_req(ireq), .inst_addr(iaddr), .inst_gnt(igt), .inst_rvalid(irv), .inst_rdata(irdata),
        .data_req(dreq), .data_we(dwe), .data_addr(daddr), .data_wdata(dwdata),
        .data_gnt(dgt), .data_rvalid(drv), .data_rdata(drdata),
        .mem_wea(wea), .mem_addr(maddr), .mem_din(mdin), .mem_dout(mdout), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(11), .DATA_W(32), .RD_LAT(4)) dut4 (
        .clk(clk), .rst(rst),
        .inst_req(ireq4), .inst_addr(iaddr4), .inst_gnt(igt4), .inst_rvalid(irv4), .inst_rdata(irdata4),
        .data_req(dreq4), .data_we(dwe4), .data_addr(daddr4), .data_wdata(dwdata4),
        .data_gnt(dgt4), .data_rvalid(drv4), .data_rdata(drdata4),
        .mem_wea(wea4), .mem_addr(maddr4), .mem_din(mdin4), .mem_dout(mdout4), .busy(busy4)
    );

    // Power-up contents of both BRAM models.
    function automatic logic [31:0] init_val(input logic [10:0] a);
        if (a == 11'd5) return 32'hDEADBEEF;
        return 32'h1000_0000 ^ (32'(a) * 32'h9E37_79B1);
    endfunction

    // BRAM model for the RD_LAT=2 instance: one output register stage.
    logic [31:0] bram [2048];
    bit          wr_valid [2048];
    logic [31:0] p1;
    always @(posedge clk) begin
        if (wea === 1'b1) begin
            bram[maddr]     <= mdin;
            wr_valid[maddr] <= 1'b1;
        end
        p1 <= wr_valid[maddr] ? bram[maddr] : init_val(maddr);
    end
    assign mdout = p1;

    // BRAM model for the RD_LAT=4 instance (read only): three output stages.
    logic [31:0] q0, q1, q2;
    always @(posedge clk) begin
        q0 <= init_val(maddr4);
        q1 <= q0;
        q2 <= q1;
    end
    assign mdout4 = q2;

    // Reference memory: words written through the arbiter, by address.
    logic [31:0] ref_wr [int];
    function automatic logic [31:0] ref_rd(input logic [10:0] a);
        if (ref_wr.exists(int'(a))) return ref_wr[int'(a)];
        return init_val(a);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ireq = 0; iaddr = 0; dreq = 0; dwe = 0; daddr = 0; dwdata = 0;
        ireq4 = 0; iaddr4 = 0; dreq4 = 0; dwe4 = 0; daddr4 = 0; dwdata4 = 0;
        step(); step();
        n_total++; if ({igt, irv, dgt, drv, wea, busy} !== 6'b0) $display("FAIL reset_ctl: got %b want 000000", {igt, irv, dgt, drv, wea, busy}); else n_pass++;
        n_total++; if (maddr !== 11'd0 || mdin !== 32'd0) $display("FAIL reset_mem: got addr %h din %h want 0 0", maddr, mdin); else n_pass++;
        n_total++; if (irdata !== 32'd0 || drdata !== 32'd0) $display("FAIL reset_rdata: got %h %h want 0 0", irdata, drdata); else n_pass++;
        n_total++; if ({igt4, irv4, dgt4, drv4, wea4, busy4} !== 6'b0 || maddr4 !== 11'd0 || mdin4 !== 32'd0) $display("FAIL reset_lat4: got %b %h %h want 0", {igt4, irv4, dgt4, drv4, wea4, busy4}, maddr4, mdin4); else n_pass++;
        rst = 1'b0;
        step();
        n_total++; if (busy !== 1'b0 || wea !== 1'b0) $display("FAIL idle_after_reset: got busy %b wea %b want 0 0", busy, wea); else n_pass++;
    endtask

    task automatic test_fetch();
        ireq = 1'b1; iaddr = 11'd5;
        step();  // E0
        n_total++; if (igt !== 1'b1 || dgt !== 1'b0) $display("FAIL fetch_gnt: got %b%b want 10", igt, dgt); else n_pass++;
        n_total++; if (busy !== 1'b1 || maddr !== 11'd5) $display("FAIL fetch_busy_addr: got %b %h want 1 005", busy, maddr); else n_pass++;
        ireq = 1'b0;
        step();  // E1
        n_total++; if (igt !== 1'b0 || irv !== 1'b0 || busy !== 1'b1) $display("FAIL fetch_e1: got gnt %b rv %b busy %b want 0 0 1", igt, irv, busy); else n_pass++;
        step();  // E2
        n_total++; if (irv !== 1'b1 || irdata !== 32'hDEADBEEF) $display("FAIL fetch_rdata: got rv %b data %h want 1 deadbeef", irv, irdata); else n_pass++;
        n_total++; if (busy !== 1'b0 || drv !== 1'b0) $display("FAIL fetch_e2_busy: got busy %b drv %b want 0 0", busy, drv); else n_pass++;
        step();  // E3
        n_total++; if (irv !== 1'b0 || irdata !== 32'hDEADBEEF) $display("FAIL fetch_hold: got rv %b data %h want 0 deadbeef", irv, irdata); else n_pass++;
    endtask

    task automatic test_write_read();
        int wea_cycles;
        dreq = 1'b1; dwe = 1'b1; daddr = 11'h7FF; dwdata = 32'h12345678;
        step();  // E0
        wea_cycles = (wea === 1'b1) ? 1 : 0;
        n_total++; if (dgt !== 1'b1 || wea !== 1'b1 || maddr !== 11'h7FF || mdin !== 32'h12345678) $display("FAIL write_accept: got gnt %b wea %b addr %h din %h want 1 1 7ff 12345678", dgt, wea, maddr, mdin); else n_pass++;
        ref_wr[int'(11'h7FF)] = 32'h12345678;
        dreq = 1'b0; dwe = 1'b0;
        step();  // E1
        n_total++; if (wea !== 1'b0 || dgt !== 1'b0 || drv !== 1'b0 || busy !== 1'b0) $display("FAIL write_e1: got wea %b gnt %b rv %b busy %b want 0 0 0 0", wea, dgt, drv, busy); else n_pass++;
        dreq = 1'b1; daddr = 11'h7FF;
        step();  // E2: earliest next accept
        if (wea === 1'b1) wea_cycles++;
        n_total++; if (dgt !== 1'b1) $display("FAIL read_after_write_gnt: got %b want 1", dgt); else n_pass++;
        dreq = 1'b0;
        step();
        if (wea === 1'b1) wea_cycles++;
        n_total++; if (drv !== 1'b0) $display("FAIL read_early_rvalid: got %b want 0", drv); else n_pass++;
        step();
        if (wea === 1'b1) wea_cycles++;
        n_total++; if (drv !== 1'b1 || drdata !== 32'h12345678) $display("FAIL read_back: got rv %b data %h want 1 12345678", drv, drdata); else n_pass++;
        step();
        n_total++; if (drv !== 1'b0 || irv !== 1'b0) $display("FAIL read_pulse: got drv %b irv %b want 0 0", drv, irv); else n_pass++;
        n_total++; if (wea_cycles != 1) $display("FAIL wea_width: got %0d cycles want 1", wea_cycles); else n_pass++;
    endtask

    task automatic test_tie();
        rst = 1'b1; step(); rst = 1'b0;
        ireq = 1'b1; iaddr = 11'd1; dreq = 1'b1; dwe = 1'b0; daddr = 11'd2;
        step();  // E0: fetch wins the first tie after reset
        n_total++; if (igt !== 1'b1 || dgt !== 1'b0) $display("FAIL tie1_winner: got igt %b dgt %b want 1 0", igt, dgt); else n_pass++;
        iaddr = 11'd3;  // fetch port keeps requesting
        step(); step();  // E2
        n_total++; if (irv !== 1'b1 || irdata !== ref_rd(11'd1)) $display("FAIL tie1_rdata: got %b %h want 1 %h", irv, irdata, ref_rd(11'd1)); else n_pass++;
        step();  // E3: both requesting, data was not served last
        n_total++; if (dgt !== 1'b1 || igt !== 1'b0) $display("FAIL tie2_winner: got igt %b dgt %b want 0 1", igt, dgt); else n_pass++;
        dreq = 1'b0;
        step(); step();  // E5
        n_total++; if (drv !== 1'b1 || drdata !== ref_rd(11'd2)) $display("FAIL tie2_rdata: got %b %h want 1 %h", drv, drdata, ref_rd(11'd2)); else n_pass++;
        step();  // E6
        n_total++; if (igt !== 1'b1 || maddr !== 11'd3) $display("FAIL tie3_fetch: got gnt %b addr %h want 1 003", igt, maddr); else n_pass++;
        ireq = 1'b0;
        step(); step();  // E8
        n_total++; if (irv !== 1'b1 || irdata !== ref_rd(11'd3)) $display("FAIL tie3_rdata: got %b %h want 1 %h", irv, irdata, ref_rd(11'd3)); else n_pass++;
    endtask

    task automatic test_no_starve();
        int  accepts;
        bit  got;
        ireq = 1'b1; iaddr = 11'd8;
        step(); step(); step();
        dreq = 1'b1; dwe = 1'b0; daddr = 11'd4;
        accepts = 0; got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            step();
            if (igt === 1'b1 || dgt === 1'b1) accepts++;
            if (dgt === 1'b1) begin got = 1'b1; dreq = 1'b0; end
        end
        n_total++; if (!got || accepts > 2) $display("FAIL data_not_starved: got gnt %b after %0d accepts want 1 within 2", got, accepts); else n_pass++;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            step();
            if (igt === 1'b1) got = 1'b1;
        end
        n_total++; if (!got) $display("FAIL fetch_not_starved: got %b want 1", got); else n_pass++;
        ireq = 1'b0;
        step(); step(); step(); step();
        n_total++; if (busy !== 1'b0) $display("FAIL starve_drain: got busy %b want 0", busy); else n_pass++;
    endtask

    task automatic test_reset_abort();
        step(); step();
        ireq = 1'b1; iaddr = 11'd5;
        step();  // E0: accepted, cnt=1
        n_total++; if (igt !== 1'b1) $display("FAIL abort_gnt: got %b want 1", igt); else n_pass++;
        ireq = 1'b0; rst = 1'b1;
        step();  // reset edge in RD
        n_total++; if ({igt, irv, dgt, drv, wea, busy} !== 6'b0) $display("FAIL abort_ctl: got %b want 000000", {igt, irv, dgt, drv, wea, busy}); else n_pass++;
        n_total++; if (maddr !== 11'd0 || mdin !== 32'd0 || irdata !== 32'd0 || drdata !== 32'd0) $display("FAIL abort_data: got %h %h %h %h want 0", maddr, mdin, irdata, drdata); else n_pass++;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            n_total++; if (irv !== 1'b0 || drv !== 1'b0) $display("FAIL abort_no_rvalid: got %b%b want 00", irv, drv); else n_pass++;
        end
        dreq = 1'b1; dwe = 1'b0; daddr = 11'd6;
        step();
        n_total++; if (dgt !== 1'b1) $display("FAIL abort_resume_gnt: got %b want 1", dgt); else n_pass++;
        dreq = 1'b0;
        step(); step();
        n_total++; if (drv !== 1'b1 || drdata !== ref_rd(11'd6)) $display("FAIL abort_resume_rdata: got %b %h want 1 %h", drv, drdata, ref_rd(11'd6)); else n_pass++;
    endtask

    task automatic test_lat4();
        dreq4 = 1'b1; dwe4 = 1'b0; daddr4 = 11'd3;
        step();  // accept edge
        n_total++; if (dgt4 !== 1'b1 || wea4 !== 1'b0 || maddr4 !== 11'd3) $display("FAIL lat4_gnt: got %b %b %h want 1 0 003", dgt4, wea4, maddr4); else n_pass++;
        dreq4 = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            step();
            n_total++; if (drv4 !== 1'b0 || busy4 !== 1'b1) $display("FAIL lat4_early: edge %0d got rv %b busy %b want 0 1", c, drv4, busy4); else n_pass++;
        end
        step();  // 4 edges after accept
        n_total++; if (drv4 !== 1'b1 || drdata4 !== init_val(11'd3)) $display("FAIL lat4_rdata: got %b %h want 1 %h", drv4, drdata4, init_val(11'd3)); else n_pass++;
        step();
        n_total++; if (drv4 !== 1'b0 || busy4 !== 1'b0 || irv4 !== 1'b0 || igt4 !== 1'b0) $display("FAIL lat4_after: got rv %b busy %b irv %b igt %b want 0", drv4, busy4, irv4, igt4); else n_pass++;
    endtask

    task automatic test_random();
        int          free_k, acc_k, rv_k;
        bit          last_d, pick_d, rv_port, exp_ig, exp_dg, exp_we, exp_busy, chk_addr;
        logic [31:0] rv_data;
        logic [10:0] exp_addr;
        rst = 1'b1; step(); rst = 1'b0;
        ireq = 0; dreq = 0;
        free_k = 0; acc_k = -1; rv_k = -1; last_d = 1'b1; rv_port = 1'b0; rv_data = '0; exp_addr = '0;
        for (int k = 0; k < 600; k++) begin
            exp_ig = 0; exp_dg = 0; exp_we = 0; chk_addr = 0;
            if (k >= free_k && (ireq || dreq)) begin
                pick_d = dreq && (!ireq || !last_d);
                last_d = pick_d;
                acc_k = k; chk_addr = 1;
                if (pick_d) begin
                    exp_dg = 1; exp_addr = daddr;
                    if (dwe) begin
                        exp_we = 1; ref_wr[int'(daddr)] = dwdata; free_k = k + 2;
                    end else begin
                        rv_k = k + 2; rv_port = 1; rv_data = ref_rd(daddr); free_k = k + 3;
                    end
                end else begin
                    exp_ig = 1; exp_addr = iaddr;
                    rv_k = k + 2; rv_port = 0; rv_data = ref_rd(iaddr); free_k = k + 3;
                end
            end
            exp_busy = (k >= acc_k) && (k < free_k - 1);
            step();
            n_total++; if (igt !== exp_ig || dgt !== exp_dg) $display("FAIL rnd_gnt k=%0d: got %b%b want %b%b", k, igt, dgt, exp_ig, exp_dg); else n_pass++;
            n_total++; if (wea !== exp_we || busy !== exp_busy) $display("FAIL rnd_wea_busy k=%0d: got %b %b want %b %b", k, wea, busy, exp_we, exp_busy); else n_pass++;
            n_total++; if (irv !== (rv_k == k && !rv_port) || drv !== (rv_k == k && rv_port)) $display("FAIL rnd_rvalid k=%0d: got %b%b want %b%b", k, irv, drv, rv_k == k && !rv_port, rv_k == k && rv_port); else n_pass++;
            if (rv_k == k) begin
                n_total++; if ((rv_port ? drdata : irdata) !== rv_data) $display("FAIL rnd_rdata k=%0d: got %h want %h", k, rv_port ? drdata : irdata, rv_data); else n_pass++;
            end
            if (chk_addr) begin
                n_total++; if (maddr !== exp_addr) $display("FAIL rnd_addr k=%0d: got %h want %h", k, maddr, exp_addr); else n_pass++;
            end
            if (exp_ig) ireq = 1'b0;
            if (exp_dg) dreq = 1'b0;
            if (!ireq && ($urandom % 3 == 0)) begin
                ireq = 1'b1;
                iaddr = ($urandom % 9 == 8) ? 11'h7FF : 11'($urandom % 8);
            end
            if (!dreq && ($urandom % 3 == 0)) begin
                dreq = 1'b1;
                dwe = 1'($urandom % 2);
                daddr = ($urandom % 9 == 8) ? 11'h7FF : 11'($urandom % 8);
                dwdata = $urandom;
            end
        end
        ireq = 0; dreq = 0;
        step(); step(); step(); step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fetch();
        test_write_read();
        test_tie();
        test_no_starve();
        test_reset_abort();
        test_lat4();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
